// File: rtl/ads8688_pkg.sv
// Shared constants, FSM state encoding and channel-scan helpers for the
// ADS8688 sequencer.
package ads8688_pkg;

    localparam logic [15:0] CMD_MAN_BASE = 16'hC000;
    localparam logic [15:0] CMD_NOOP     = 16'h0000;
    localparam int          CH_SHIFT     = 10;
    localparam int          FRAME_BITS   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } seq_state_e;

    // Lowest enabled channel index >= from; bit 3 flags that one was found.
    function automatic logic [3:0] find_ch(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] man_cmd(input logic [2:0] ch);
        return CMD_MAN_BASE | (16'(ch) << CH_SHIFT);
    endfunction

endpackage

// File: rtl/ads8688_spi_frame.sv
// One 32-SCLK SPI frame (CPOL=0/CPHA=0): shifts tx_word out MSB first and
// captures the second half-frame from miso into rx_word.
module ads8688_spi_frame
    import ads8688_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        frame_start,
    input  logic [31:0] tx_word,
    input  logic        miso,
    output logic        sclk,
    output logic        csn,
    output logic        mosi,
    output logic        frame_done,
    output logic [15:0] rx_word
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [5:0] RX_FROM  = 6'(FRAME_BITS / 2);

    logic             r_active;
    logic             r_tail;
    logic             r_sclk;
    logic             r_csn;
    logic [DIV_W-1:0] r_div;
    logic [5:0]       r_bit;
    logic [31:0]      r_sh;
    logic [15:0]      r_rx;
    logic             w_tick;

    assign w_tick = r_active && !r_tail && (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_active <= 1'b0;
            r_tail   <= 1'b0;
            r_sclk   <= 1'b0;
            r_csn    <= 1'b1;
            r_div    <= '0;
            r_bit    <= '0;
            r_sh     <= '0;
            r_rx     <= '0;
        end else if (frame_start) begin
            r_active <= 1'b1;
            r_tail   <= 1'b0;
            r_sclk   <= 1'b0;
            r_csn    <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_sh     <= tx_word;
        end else if (r_active) begin
            if (r_tail) begin
                // csn releases one clk after the final falling edge
                r_active <= 1'b0;
                r_tail   <= 1'b0;
                r_csn    <= 1'b1;
            end else if (w_tick) begin
                r_div  <= '0;
                r_sclk <= ~r_sclk;
                if (!r_sclk) begin
                    if (r_bit >= RX_FROM) begin
                        r_rx <= {r_rx[14:0], miso};
                    end
                end else begin
                    r_sh  <= {r_sh[30:0], 1'b0};
                    r_bit <= r_bit + 6'd1;
                    if (r_bit == LAST_BIT) begin
                        r_tail <= 1'b1;
                    end
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign sclk       = r_sclk;
    assign csn        = r_csn;
    assign mosi       = r_sh[31];
    assign frame_done = r_active && r_tail;
    assign rx_word    = r_rx;

endmodule

// File: rtl/ads8688_seq_ctrl.sv
// ADS8688 manual-channel sequencer: commands each enabled channel in turn and
// reports pipelined results one frame later, ending with a NO_OP flush frame.
module ads8688_seq_ctrl
    import ads8688_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int CLK_DIV = 4,
    parameter int CSH_CYC = 2
) (
    input  logic           clk,
    input  logic           arstn,
    input  logic           start,
    input  logic           stop,
    input  logic           cont,
    input  logic [NCH-1:0] ch_mask,
    output logic           sclk,
    output logic           csn,
    output logic           mosi,
    input  logic           miso,
    output logic           busy,
    output logic           res_valid,
    output logic [2:0]     res_ch,
    output logic [15:0]    res_data,
    output logic           done,
    output logic           cfg_err
);

    localparam int GAP_W = (CSH_CYC > 1) ? $clog2(CSH_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSH_CYC - 1);

    seq_state_e       r_state;
    seq_state_e       w_state_n;
    logic [NCH-1:0]   r_mask;
    logic             r_cont;
    logic             r_stop;
    logic [2:0]       r_cur_ch;
    logic [2:0]       r_prev_ch;
    logic             r_prev_vld;
    logic [GAP_W-1:0] r_gap;
    logic             r_res_valid;
    logic [2:0]       r_res_ch;
    logic [15:0]      r_res_data;
    logic             r_cfg_err;

    logic [7:0]       w_mask_in8;
    logic [7:0]       w_mask_lat8;
    logic [3:0]       w_first;
    logic [3:0]       w_after;
    logic [3:0]       w_wrap;
    logic             w_stop_seen;
    logic             w_fstart;
    logic             w_accept;
    logic [2:0]       w_next_ch;
    logic [15:0]      w_cmd;
    logic             w_frame_done;
    logic [15:0]      w_rx_word;

    always_comb begin
        w_mask_in8  = '0;
        w_mask_lat8 = '0;
        for (int i = 0; i < NCH; i++) begin
            w_mask_in8[i]  = ch_mask[i];
            w_mask_lat8[i] = r_mask[i];
        end
    end

    assign w_first     = find_ch(w_mask_in8, 4'd0);
    assign w_after     = find_ch(w_mask_lat8, {1'b0, r_cur_ch} + 4'd1);
    assign w_wrap      = find_ch(w_mask_lat8, 4'd0);
    assign w_stop_seen = r_stop || stop;

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_fstart  = 1'b0;
        w_accept  = 1'b0;
        w_next_ch = r_cur_ch;
        w_cmd     = CMD_NOOP;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && w_first[3]) begin
                    w_state_n = ST_FRAME;
                    w_fstart  = 1'b1;
                    w_accept  = 1'b1;
                    w_next_ch = w_first[2:0];
                    w_cmd     = man_cmd(w_first[2:0]);
                end
            end
            ST_FRAME: begin
                if (w_frame_done) w_state_n = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_fstart = 1'b1;
                    if (w_after[3]) begin
                        w_state_n = ST_FRAME;
                        w_next_ch = w_after[2:0];
                        w_cmd     = man_cmd(w_after[2:0]);
                    end else if (r_cont && !w_stop_seen && w_wrap[3]) begin
                        // next sequence's first command doubles as the flush
                        w_state_n = ST_FRAME;
                        w_next_ch = w_wrap[2:0];
                        w_cmd     = man_cmd(w_wrap[2:0]);
                    end else begin
                        w_state_n = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_frame_done) w_state_n = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_mask      <= '0;
            r_cont      <= 1'b0;
            r_stop      <= 1'b0;
            r_cur_ch    <= '0;
            r_prev_ch   <= '0;
            r_prev_vld  <= 1'b0;
            r_gap       <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_cfg_err   <= (r_state == ST_IDLE) && start && !w_first[3];
            r_gap       <= (r_state == ST_GAP) ? r_gap + GAP_W'(1) : '0;
            if (w_accept) begin
                r_mask     <= ch_mask;
                r_cont     <= cont;
                r_stop     <= 1'b0;
                r_prev_vld <= 1'b0;
            end else if ((r_state != ST_IDLE) && stop) begin
                r_stop <= 1'b1;
            end
            if (w_fstart) begin
                r_cur_ch <= w_next_ch;
            end
            // data in this frame belongs to the previous command frame
            if (w_frame_done) begin
                if (r_prev_vld) begin
                    r_res_valid <= 1'b1;
                    r_res_ch    <= r_prev_ch;
                    r_res_data  <= w_rx_word;
                end
                r_prev_ch  <= r_cur_ch;
                r_prev_vld <= (r_state == ST_FRAME);
            end
        end
    end

    ads8688_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk         (clk),
        .arstn       (arstn),
        .frame_start (w_fstart),
        .tx_word     ({w_cmd, 16'h0000}),
        .miso        (miso),
        .sclk        (sclk),
        .csn         (csn),
        .mosi        (mosi),
        .frame_done  (w_frame_done),
        .rx_word     (w_rx_word)
    );

    assign res_valid = r_res_valid;
    assign res_ch    = r_res_ch;
    assign res_data  = r_res_data;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_ads8688_seq_ctrl.sv
// Bench for ads8688_seq_ctrl: an ADC-side monitor decodes SPI frames and
// drives miso; each run is compared against the frame/result lists implied by the mask.
module tb_ads8688_seq_ctrl;

    localparam int NCH     = 4;
    localparam int CLK_DIV = 4;
    localparam int CSH_CYC = 2;
    localparam int HALF    = CLK_DIV / 2;
    localparam int LIMIT   = 6000;

    logic           clk   = 1'b0;
    logic           arstn = 1'b0;
    logic           start = 1'b0;
    logic           stop  = 1'b0;
    logic           cont  = 1'b0;
    logic           miso  = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic           sclk, csn, mosi, busy, res_valid, done, cfg_err;
    logic [2:0]     res_ch;
    logic [15:0]    res_data;

    ads8688_seq_ctrl #(
        .NCH     (NCH),
        .CLK_DIV (CLK_DIV),
        .CSH_CYC (CSH_CYC)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .sclk      (sclk),
        .csn       (csn),
        .mosi      (mosi),
        .miso      (miso),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_data  (res_data),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // ADC-side monitor state
    logic        prev_csn = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        gap_busy = 1'b0;
    logic        use_fixed = 1'b0;
    logic [15:0] fixed_data = 16'h0000;
    logic [15:0] mosi_word, fdata;
    int          rc = 0, lo_cnt = 0, tail_cnt = 0, hi_cnt = 0;
    int          n_fall = 0, n_done = 0, n_cfg = 0, n_busy = 0, rise_total = 0;
    logic [15:0] mosi_q[$];
    logic [15:0] fdata_q[$];
    logic [15:0] rdata_q[$];
    logic [2:0]  rch_q[$];

    always @(negedge clk) begin
        if (arstn) begin
            prev_csn = 1'b1;
            prev_sclk = 1'b0;
            gap_busy = 1'b0;
            rc = 0;
            hi_cnt = 0;
        end else begin
            if (done) n_done++;
            if (cfg_err) n_cfg++;
            if (busy) n_busy++;
            if (res_valid) begin
                rch_q.push_back(res_ch);
                rdata_q.push_back(res_data);
                chk("strobe_on_csn_rise", {30'd0, prev_csn, csn}, 32'd1);
            end
            if (prev_csn && !csn) begin
                if (gap_busy) chk("csn_high_gap", hi_cnt, CSH_CYC);
                n_fall++;
                rc = 0;
                lo_cnt = 0;
                mosi_word = 16'h0000;
                fdata = use_fixed ? fixed_data : 16'($urandom);
                fdata_q.push_back(fdata);
                miso = 1'b0;
            end
            if (!csn && !sclk && rc == 0) lo_cnt++;
            if (!csn && sclk && !prev_sclk) begin
                rc++;
                rise_total++;
                if (rc == 1) chk("sclk_lead", lo_cnt, HALF);
                if (rc <= 16) mosi_word = {mosi_word[14:0], mosi};
            end
            if (!csn && !sclk && prev_sclk) begin
                tail_cnt = 0;
                if (rc >= 16 && rc < 32) miso = fdata[31-rc];
            end
            if (!csn && !sclk && rc == 32) tail_cnt++;
            if (!prev_csn && csn) begin
                mosi_q.push_back(mosi_word);
                chk("frame_rises", rc, 32);
                chk("csn_tail", tail_cnt, 1);
                hi_cnt = 0;
            end
            if (csn && busy) hi_cnt++;
            gap_busy = csn && busy;
            prev_csn = csn;
            prev_sclk = sclk;
        end
    end

    task automatic clear_mon();
        mosi_q.delete();
        fdata_q.delete();
        rdata_q.delete();
        rch_q.delete();
        n_fall = 0;
        n_done = 0;
        n_cfg = 0;
        n_busy = 0;
        rise_total = 0;
    endtask

    task automatic run_case(input string tag, input logic [NCH-1:0] mask, input bit cmode,
                            input int nseq, input bit disturb);
        int chans[$];
        int m, nres, nfr, thr, cyc;
        bit stopped;
        logic [31:0] obs, exp_v;
        for (int k = 0; k < NCH; k++) if (mask[k]) chans.push_back(k);
        m = chans.size();
        nres = nseq * m;
        nfr = nres + 1;
        thr = m * (nseq - 1) + 1;
        clear_mon();
        @(negedge clk);
        ch_mask = mask;
        cont = cmode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        stopped = 1'b0;
        while (n_done == 0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            stop = 1'b0;
            if (cmode && !stopped && n_fall >= thr) begin
                stop = 1'b1;
                stopped = 1'b1;
            end
            if (disturb) begin
                ch_mask = NCH'($urandom);
                cont = 1'($urandom);
                start = busy && ($urandom_range(0, 7) == 0);
            end
        end
        start = 1'b0;
        stop = 1'b0;
        chk({tag, " done_in_time"}, 32'(cyc < LIMIT), 32'd1);
        repeat (20) @(negedge clk);

        chk({tag, " frames"}, mosi_q.size(), nfr);
        for (int i = 0; i < nfr; i++) begin
            exp_v = (i < nres) ? 32'h0000_C000 + 32'(chans[i % m] * 1024) : 32'h0;
            obs = (i < mosi_q.size()) ? {16'h0, mosi_q[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s mosi[%0d]", tag, i), obs, exp_v);
        end
        chk({tag, " results"}, rch_q.size(), nres);
        for (int i = 0; i < nres; i++) begin
            obs = (i < rch_q.size()) ? 32'(rch_q[i]) : 32'hFFFF_FFFF;
            chk($sformatf("%s res_ch[%0d]", tag, i), obs, chans[i % m]);
            obs = (i < rdata_q.size()) ? {16'h0, rdata_q[i]} : 32'hFFFF_FFFF;
            exp_v = (i + 1 < fdata_q.size()) ? {16'h0, fdata_q[i+1]} : 32'hEEEE_EEEE;
            chk($sformatf("%s res_data[%0d]", tag, i), obs, exp_v);
        end
        chk({tag, " done_count"}, n_done, 1);
        chk({tag, " sclk_rises"}, rise_total, 32 * nfr);
        chk({tag, " no_cfg_err"}, n_cfg, 0);
        chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, " csn_end"}, {31'd0, csn}, 32'd1);
    endtask

    initial begin
        int cyc;
        logic [NCH-1:0] rm;
        bit rc_mode;

        #1 arstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst csn", {31'd0, csn}, 32'd1);
        chk("rst sclk", {31'd0, sclk}, 32'd0);
        chk("rst mosi", {31'd0, mosi}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("rst res_ch", {29'd0, res_ch}, 32'd0);
        chk("rst res_data", {16'd0, res_data}, 32'd0);
        arstn = 1'b0;
        repeat (2) @(negedge clk);

        use_fixed = 1'b1;
        fixed_data = 16'hA5A5;
        run_case("m0010", 4'b0010, 1'b0, 1, 1'b0);
        chk("m0010 data_a5a5", (rdata_q.size() > 0) ? {16'h0, rdata_q[0]} : 32'hFFFF_FFFF, 32'h0000_A5A5);
        use_fixed = 1'b0;

        run_case("m1011", 4'b1011, 1'b0, 1, 1'b0);

        clear_mon();
        @(negedge clk);
        ch_mask = '0;
        cont = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("mask0 cfg_err_pulses", n_cfg, 1);
        chk("mask0 no_frame", n_fall, 0);
        chk("mask0 never_busy", n_busy, 0);
        chk("mask0 no_done", n_done, 0);
        chk("mask0 csn", {31'd0, csn}, 32'd1);

        run_case("cont0101", 4'b0101, 1'b1, 2, 1'b0);

        clear_mon();
        @(negedge clk);
        ch_mask = 4'b0010;
        cont = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rc < 10 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort reach_bit10", 32'(cyc < LIMIT), 32'd1);
        #2 arstn = 1'b1;
        #1;
        chk("abort csn", {31'd0, csn}, 32'd1);
        chk("abort sclk", {31'd0, sclk}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort mosi", {31'd0, mosi}, 32'd0);
        chk("abort res_valid", {31'd0, res_valid}, 32'd0);
        repeat (3) @(negedge clk);
        arstn = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort no_strobe", rch_q.size(), 0);
        chk("abort no_done", n_done, 0);
        run_case("post_reset", 4'b0010, 1'b0, 1, 1'b0);

        run_case("disturb1011", 4'b1011, 1'b0, 1, 1'b1);
        run_case("disturb_cont0110", 4'b0110, 1'b1, 2, 1'b1);

        for (int t = 0; t < 6; t++) begin
            rm = NCH'($urandom_range(1, (1 << NCH) - 1));
            rc_mode = 1'($urandom);
            run_case($sformatf("rand%0d", t), rm, rc_mode,
                     rc_mode ? $urandom_range(1, 3) : 1, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ads8688_seq_ctrl.md
ADS8688_SEQ_CTRL -- requirements
Module: ads8688_seq_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 8: number of ADC channels (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK period (even, >=2).
REQ-003 SHALL have parameter CSH_CYC, default 2: clk cycles csn stays high between frames (>=1).
REQ-004 SHALL have ports:
- clk  in  1  clock.
- arstn  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a sequence.
- stop  in  1  in continuous mode, end after the current sequence.
- cont  in  1  continuous mode, sampled at start.
- ch_mask  in  NCH  enabled channels, sampled at start.
- sclk, csn, mosi  out  1 each  SPI master, CPOL=0/CPHA=0.
- miso  in  1  ADC SDO.
- busy  out  1  sequence in progress.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  3  channel of res_data.
- res_data  out  16  conversion result.
- done  out  1  one-cycle pulse at sequence end.
- cfg_err  out  1  one-cycle pulse: start with ch_mask==0.

Function
REQ-005 SHALL run states IDLE, FRAME, GAP, FLUSH, DONE.
- IDLE->FRAME on start with mask!=0.
- FRAME->GAP at frame end.
- GAP->FRAME while command frames remain.
- GAP->FLUSH after the last channel frame when not continuing.
- FLUSH->DONE at frame end; DONE->IDLE after 1 cycle.
REQ-006 SHALL latch ch_mask and cont on accepted start; input changes during busy SHALL have no effect.
REQ-007 SHALL ignore start while busy; start with ch_mask==0 in IDLE SHALL pulse cfg_err and leave csn high.
REQ-008 SHALL visit enabled channels in ascending index order, one 32-SCLK frame per channel.
REQ-009 Command frame for channel k SHALL shift 16'hC000 | (k<<10) MSB-first on SCLK bits 1-16; bits 17-32 mosi=0.
REQ-010 FLUSH frame SHALL send 16'h0000 (NO_OP).
REQ-011 mosi SHALL change on SCLK falling edges (first bit valid when csn falls); miso SHALL be sampled on SCLK rising edges 17-32, MSB first.
REQ-012 Data captured in frame n SHALL be reported as the channel commanded in frame n-1; data from the first frame after IDLE SHALL be discarded.
REQ-013 For m enabled channels, a single sequence SHALL produce exactly m+1 frames and m results.
REQ-014 Timing:
- csn falls 1 clk after start is accepted.
- First SCLK rise occurs CLK_DIV/2 clks after csn falls.
- SCLK high and low phases are CLK_DIV/2 clks each.
- csn rises 1 clk after the 32nd SCLK fall.
- csn stays high CSH_CYC clks between frames.
REQ-015 res_valid, res_ch and res_data SHALL update in the clk where csn rises; res_ch/res_data SHALL hold until the next strobe.
REQ-016 In continuous mode, the next sequence's first command frame SHALL replace FLUSH, and its data SHALL be reported as the previous sequence's last channel.
REQ-017 If stop is seen at any time during the current sequence, FLUSH SHALL follow that sequence's last channel frame.
REQ-018 done SHALL pulse in DONE, once per start, with busy=0 in the following cycle.

Reset
REQ-019 arstn high SHALL immediately force:
- csn=1, sclk=0, mosi=0.
- busy=0, res_valid=0, done=0, cfg_err=0.
- res_ch=0, res_data=0, state IDLE, latched mask 0.
REQ-020 Reset mid-frame SHALL abort the frame without a result; the first start after release SHALL behave as from power-up.

Structure
REQ-021 Package ads8688_pkg SHALL hold CMD_MAN_BASE=16'hC000, CMD_NOOP=16'h0000, CH_SHIFT=10, FRAME_BITS=32 and the state enum.
REQ-022 A sub-module ads8688_spi_frame SHALL generate SCLK/csn for one 32-bit frame: 32-bit shift register, divider, frame_start in, frame_done/rx_word out.

Verification (NCH=4, CLK_DIV=4, CSH_CYC=2)
REQ-023 Mask 4'b0010, miso frame-2 data 16'hA5A5:
- mosi frames are C400, 0000; 64 SCLK rises.
- One strobe with ch=1, data=A5A5, then done.
REQ-024 Mask 4'b1011:
- mosi frames are C000, C400, CC00, 0000.
- Strobes are ch 0, 1, 3 with their frame data.
REQ-025 Mask 0:
- cfg_err pulses for 1 cycle.
- csn stays 1, busy stays 0, no done.
REQ-026 Continuous, mask 4'b0101, stop asserted during the second sequence:
- mosi frames are C000, C800, C000, C800, 0000.
- Strobes are ch 0, 2, 0, 2; one done.
REQ-027 Reset asserted at SCLK bit 10 of frame 1:
- csn=1, sclk=0, busy=0 immediately; no strobe.
- Next start yields a correct C400 sequence.
REQ-028 Start repeated and ch_mask changed mid-sequence: output identical to the undisturbed run.
